fifo_wr_serializer: RTL and testbench

//  Write-side feeder for the async FIFO: accepts multi-byte words on a valid/ready

---
 rtl/fifo_stream_pkg.sv | 17 +
 rtl/fifo_wr_serializer.sv | 107 ++++++++++
 tb/tb_fifo_wr_serializer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing helpers for the FIFO write-side stream feeder.
package fifo_stream_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_IN_BYTES   = 4;

   // The length field must also encode the illegal value IN_BYTES+1.
   function automatic int len_w(input int in_bytes);
      return $clog2(in_bytes + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_serializer.sv
// Serialises multi-byte valid/ready words onto the async FIFO write port, one byte
// per wr_clk, honouring fifo_full and keeping write-side statistics.
module fifo_wr_serializer
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IN_BYTES   = DEF_IN_BYTES,
   parameter int MSB_FIRST  = 0,
   parameter int CNT_WIDTH  = 16,
   localparam int LEN_W     = len_w(IN_BYTES)
) (
   input  logic                           wr_clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic [IN_BYTES*DATA_WIDTH-1:0] in_data,
   input  logic [LEN_W-1:0]               in_len,
   output logic                           in_ready,
   input  logic                           fifo_full,
   output logic                           fifo_wr,
   output logic [DATA_WIDTH-1:0]          fifo_wdata,
   output logic                           busy,
   output logic                           len_err,
   output logic [CNT_WIDTH-1:0]           bytes_written,
   output logic [CNT_WIDTH-1:0]           words_accepted
);

   state_e                               state_q, state_d;
   logic [IN_BYTES-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
   logic [LEN_W-1:0]                    len_q, len_d;
   logic [LEN_W-1:0]                    idx_q, idx_d;
   logic                                len_err_q;
   logic [CNT_WIDTH-1:0]                bytes_written_q;
   logic [CNT_WIDTH-1:0]                words_accepted_q;

   logic                                accept;
   logic                                len_ok;
   logic                                load;
   logic                                last_byte;
   logic [LEN_W-1:0]                    lane;
   logic [DATA_WIDTH-1:0]               lane_data;

   assign len_ok    = (in_len != '0) && (in_len <= LEN_W'(IN_BYTES));
   assign last_byte = (idx_q == len_q - LEN_W'(1));

   // NOTE: fifo_full reaches in_ready combinationally so a new word can be loaded
   // in the same cycle the last byte leaves, giving back-to-back bytes.
   assign fifo_wr  = (state_q == SEND) & ~fifo_full;
   assign in_ready = (state_q == IDLE) | (fifo_wr & last_byte);
   assign accept   = in_valid & in_ready;
   assign load     = accept & len_ok;

   assign lane = (MSB_FIRST != 0) ? (len_q - LEN_W'(1) - idx_q) : idx_q;

   always_comb begin
      lane_data = '0;
      for (int i = 0; i < IN_BYTES; i++) begin
         if (lane == LEN_W'(i)) lane_data = hold_q[i];
      end
   end

   assign fifo_wdata = (state_q == SEND) ? lane_data : '0;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      len_d   = len_q;
      idx_d   = idx_q;
      if (load) begin
         // Covers both IDLE->SEND and the zero-bubble reload on the last byte.
         state_d = SEND;
         hold_d  = in_data;
         len_d   = in_len;
         idx_d   = '0;
      end else if (fifo_wr) begin
         if (last_byte) state_d = IDLE;
         else           idx_d   = idx_q + LEN_W'(1);
      end
   end

   // NOTE: the hold register is a handful of flops, not a RAM, so it is cleared
   // with the rest of the state; a mid-word reset leaves no stale lanes behind.
   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         hold_q           <= '0;
         len_q            <= '0;
         idx_q            <= '0;
         len_err_q        <= 1'b0;
         bytes_written_q  <= '0;
         words_accepted_q <= '0;
      end else begin
         state_q          <= state_d;
         hold_q           <= hold_d;
         len_q            <= len_d;
         idx_q            <= idx_d;
         len_err_q        <= accept & ~len_ok;
         bytes_written_q  <= bytes_written_q + CNT_WIDTH'(fifo_wr);
         words_accepted_q <= words_accepted_q + CNT_WIDTH'(load);
      end
   end

   assign busy           = (state_q == SEND);
   assign len_err        = len_err_q;
   assign bytes_written  = bytes_written_q;
   assign words_accepted = words_accepted_q;

endmodule

// File: tb/tb_fifo_wr_serializer.sv
// Directed and scoreboarded bench for fifo_wr_serializer, LSB-first and MSB-first.
module tb_fifo_wr_serializer;

   logic        wr_clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic [2:0]  in_len;
   logic        fifo_full;

   logic        in_ready0, fifo_wr0, busy0, len_err0;
   logic [7:0]  wdata0;
   logic [15:0] bw0, wa0;
   logic        in_ready1, fifo_wr1, busy1, len_err1;
   logic [7:0]  wdata1;
   logic [15:0] bw1, wa1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 wr_clk = ~wr_clk;

   fifo_wr_serializer #(.MSB_FIRST(0)) dut_lsb (
      .wr_clk(wr_clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_len(in_len), .in_ready(in_ready0), .fifo_full(fifo_full),
      .fifo_wr(fifo_wr0), .fifo_wdata(wdata0), .busy(busy0), .len_err(len_err0),
      .bytes_written(bw0), .words_accepted(wa0)
   );

   fifo_wr_serializer #(.MSB_FIRST(1)) dut_msb (
      .wr_clk(wr_clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_len(in_len), .in_ready(in_ready1), .fifo_full(fifo_full),
      .fifo_wr(fifo_wr1), .fifo_wdata(wdata1), .busy(busy1), .len_err(len_err1),
      .bytes_written(bw1), .words_accepted(wa1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs are sampled 1 later.
   task automatic next();
      @(posedge wr_clk);
      #2;
   endtask

   logic [7:0] exp_lsb [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] exp_msb [8] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   initial begin
      int words_sent, bytes_tot, cyc, wr_seen;
      bit acc_flag;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; fifo_full = 1'b0;

      // Reset state
      repeat (3) @(posedge wr_clk);
      #1;
      chk("rst_in_ready", in_ready0, 1);
      chk("rst_fifo_wr", fifo_wr0, 0);
      chk("rst_wdata", wdata0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_len_err", len_err0, 0);
      chk("rst_bytes", bw0, 0);
      chk("rst_words", wa0, 0);
      #1 rst_n = 1'b1;

      // 1: single 4-byte word, both byte orders
      next(); in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_len = 3'd4;
      #1 chk("t1_ready_idle", in_ready0, 1);
      next(); in_valid = 1'b0;
      #1 chk("t1_first_wr", fifo_wr0, 1);
      chk("t1_busy", busy0, 1);
      chk("t1_ready_mid", in_ready0, 0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next();
         #1;
         chk($sformatf("t1_lsb_b%0d", i), wdata0, exp_lsb[i]);
         chk($sformatf("t1_msb_b%0d", i), wdata1, exp_msb[i]);
      end
      chk("t1_ready_last", in_ready0, 1);
      next(); #1;
      chk("t1_idle_wr", fifo_wr0, 0);
      chk("t1_idle_busy", busy0, 0);
      chk("t1_idle_wdata", wdata0, 0);
      chk("t1_bytes", bw0, 4);
      chk("t1_words", wa0, 1);

      // 2: two words streamed, no bubble between them
      next(); in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_len = 3'd4;
      for (int i = 0; i < 8; i++) begin
         next();
         if (i == 3) begin in_valid = 1'b1; in_data = 32'h44332211; end
         else in_valid = 1'b0;
         #1;
         chk($sformatf("t2_wr_%0d", i), fifo_wr1, 1);
         chk($sformatf("t2_lsb_%0d", i), wdata0, exp_lsb[i]);
         chk($sformatf("t2_msb_%0d", i), wdata1, exp_msb[i]);
         if (i == 3) chk("t2_ready_reload", in_ready1, 1);
      end
      next(); #1;
      chk("t2_idle_wr", fifo_wr1, 0);
      chk("t2_bytes", bw1, 12);
      chk("t2_words", wa1, 3);

      // 3: len=2 word with a 3-cycle full stall after the first byte
      next(); in_valid = 1'b1; in_data = 32'h11223344; in_len = 3'd2;
      next(); in_valid = 1'b0;
      #1 chk("t3_b0_wr", fifo_wr0, 1);
      chk("t3_b0_lsb", wdata0, 8'h44);
      chk("t3_b0_msb", wdata1, 8'h33);
      for (int i = 0; i < 3; i++) begin
         next(); fifo_full = 1'b1;
         #1;
         chk($sformatf("t3_stall_wr_%0d", i), fifo_wr0, 0);
         chk($sformatf("t3_stall_lsb_%0d", i), wdata0, 8'h33);
         chk($sformatf("t3_stall_msb_%0d", i), wdata1, 8'h44);
         chk($sformatf("t3_stall_ready_%0d", i), in_ready0, 0);
      end
      next(); fifo_full = 1'b0;
      #1 chk("t3_b1_wr", fifo_wr0, 1);
      chk("t3_b1_lsb", wdata0, 8'h33);
      chk("t3_b1_ready", in_ready0, 1);
      next(); #1;
      chk("t3_idle_wr", fifo_wr0, 0);
      chk("t3_bytes", bw0, 14);
      chk("t3_words", wa0, 4);

      // 4: illegal lengths 0 and 5 are consumed and dropped
      next(); in_valid = 1'b1; in_data = 32'hCAFEF00D; in_len = 3'd0;
      #1 chk("t4_ready_len0", in_ready0, 1);
      next(); in_len = 3'd5;
      #1 chk("t4_err_len0", len_err0, 1);
      chk("t4_ready_len5", in_ready0, 1);
      chk("t4_nowr_a", fifo_wr0, 0);
      next(); in_valid = 1'b0;
      #1 chk("t4_err_len5", len_err0, 1);
      chk("t4_nowr_b", fifo_wr0, 0);
      next(); #1;
      chk("t4_err_clear", len_err0, 0);
      chk("t4_busy", busy0, 0);
      chk("t4_words", wa0, 4);
      chk("t4_bytes", bw0, 14);
      in_valid = 1'b1; in_data = 32'h000000EE; in_len = 3'd1;
      next(); in_valid = 1'b0;
      #1 chk("t4_legal_wr", fifo_wr0, 1);
      chk("t4_legal_data", wdata0, 8'hEE);
      chk("t4_legal_ready", in_ready0, 1);
      next(); #1;
      chk("t4_legal_words", wa0, 5);
      chk("t4_legal_bytes", bw0, 15);

      // 5: reset after the second byte of a 4-byte word
      next(); in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_len = 3'd4;
      next(); in_valid = 1'b0;
      #1 chk("t5_b0", wdata0, 8'hAA);
      next(); #1 chk("t5_b1", wdata0, 8'hBB);
      next(); rst_n = 1'b0;
      #1 chk("t5_rst_wr", fifo_wr0, 0);
      chk("t5_rst_busy", busy0, 0);
      chk("t5_rst_wdata", wdata0, 0);
      chk("t5_rst_ready", in_ready0, 1);
      chk("t5_rst_bytes", bw0, 0);
      chk("t5_rst_words", wa0, 0);
      next(); rst_n = 1'b1;
      wr_seen = 0;
      for (int i = 0; i < 4; i++) begin
         next(); #1;
         if (fifo_wr0 || fifo_wr1) wr_seen++;
      end
      chk("t5_no_more_writes", wr_seen, 0);

      // 6: random lengths and full traffic against byte scoreboards
      words_sent = 0; bytes_tot = 0; cyc = 0; acc_flag = 1'b0;
      while ((words_sent < 200 || in_valid || acc_flag || q0.size() != 0 || q1.size() != 0)
             && cyc < 8000) begin
         next(); cyc++;
         if (acc_flag) in_valid = 1'b0;
         acc_flag = 1'b0;
         fifo_full = ($urandom_range(0, 3) == 0);
         if (!in_valid && words_sent < 200 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_len   = 3'($urandom_range(1, 4));
         end
         #1;
         if (fifo_wr0 && fifo_full) chk("t6_wr_while_full", 1, 0);
         if (fifo_wr0) begin
            if (q0.size() == 0) chk("t6_lsb_underflow", 1, 0);
            else chk("t6_lsb_byte", wdata0, q0.pop_front());
         end
         if (fifo_wr1) begin
            if (q1.size() == 0) chk("t6_msb_underflow", 1, 0);
            else chk("t6_msb_byte", wdata1, q1.pop_front());
         end
         if (in_valid && in_ready0) begin
            for (int k = 0; k < int'(in_len); k++) q0.push_back(in_data[8*k +: 8]);
            for (int k = int'(in_len) - 1; k >= 0; k--) q1.push_back(in_data[8*k +: 8]);
            bytes_tot += int'(in_len);
            words_sent++;
            acc_flag = 1'b1;
         end
      end
      chk("t6_within_budget", (cyc < 8000), 1);
      fifo_full = 1'b0;
      next(); #1;
      chk("t6_bytes", bw0, bytes_tot);
      chk("t6_words", wa0, 200);
      chk("t6_idle", busy0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
